// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: data-memory load/store over req/gnt/rvalid, load formatting, MEM/WB register.
// Optional build macro MISALIGN_TRAP_EN adds misalign_o and suppresses misaligned H/HU/W accesses.
module mem_stage_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            reg_write_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [2:0]      funct3_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_write_o,
  output logic            valid_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign_o
`endif
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t     state;
  logic       mem_op;
  logic       misalign;
  logic       issue;
  logic [4:0] ld_rd;
  logic       ld_we;
  logic [2:0] ld_f3;
  logic [1:0] ld_off;

  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  // Request fields are pure functions of the held EX/MEM inputs, so they stay stable until granted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    mem_op       = mem_read_i | mem_write_i;
    misalign     = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = '0;
`ifdef MISALIGN_TRAP_EN
    case (funct3_i[1:0])
      2'b01:   misalign = mem_op & alu_result_i[0];
      2'b10:   misalign = mem_op & (|alu_result_i[1:0]);
      default: misalign = 1'b0;
    endcase
`endif
    issue = (state == IDLE) && valid_i && mem_op && !misalign;
    if (issue) begin
      dmem_req_o  = 1'b1;
      dmem_we_o   = mem_write_i;
      dmem_addr_o = {alu_result_i[XLEN-1:2], 2'b00};
      case (funct3_i[1:0])
        2'b00: begin
          dmem_be_o    = 4'b0001 << alu_result_i[1:0];
          dmem_wdata_o = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          dmem_be_o    = alu_result_i[1] ? 4'b1100 : 4'b0011;
          dmem_wdata_o = {2{store_data_i[15:0]}};
        end
        default: begin
          dmem_be_o    = 4'b1111;
          dmem_wdata_o = store_data_i;
        end
      endcase
    end
    stall_o = (state == LOAD_WAIT) || (issue && !dmem_gnt_i);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      wb_data_o   <= '0;
      rd_addr_o   <= 5'd0;
      reg_write_o <= 1'b0;
      valid_o     <= 1'b0;
      // NOTE: the captured load context is a handful of flops, not a memory, so it is reset too.
      ld_rd       <= 5'd0;
      ld_we       <= 1'b0;
      ld_f3       <= 3'd0;
      ld_off      <= 2'd0;
`ifdef MISALIGN_TRAP_EN
      misalign_o  <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (!mem_op || misalign) begin
              // ALU result, or a trapped access reporting its faulting address.
              wb_data_o   <= alu_result_i;
              rd_addr_o   <= rd_addr_i;
              reg_write_o <= !misalign && reg_write_i && (rd_addr_i != 5'd0);
              valid_o     <= 1'b1;
`ifdef MISALIGN_TRAP_EN
              misalign_o  <= misalign;
`endif
            end else if (dmem_gnt_i) begin
              if (mem_write_i) begin
                wb_data_o   <= alu_result_i;
                rd_addr_o   <= rd_addr_i;
                reg_write_o <= 1'b0;
                valid_o     <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                misalign_o  <= 1'b0;
`endif
              end else begin
                ld_rd  <= rd_addr_i;
                ld_we  <= reg_write_i;
                ld_f3  <= funct3_i;
                ld_off <= alu_result_i[1:0];
                state  <= LOAD_WAIT;
              end
            end
          end
        end
        LOAD_WAIT: begin
          if (dmem_rvalid_i) begin
            wb_data_o   <= fmt_load(ld_f3, ld_off, dmem_rdata_i);
            rd_addr_o   <= ld_rd;
            reg_write_o <= ld_we && (ld_rd != 5'd0);
            valid_o     <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            misalign_o  <= 1'b0;
`endif
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: expected retirements are queued at issue and popped on valid_o.
module tb_mem_stage_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic [4:0]  rd_addr_i;
  logic        reg_write_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] wb_data_o;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o;
  logic        valid_o;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        chk;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .alu_result_i(alu_result_i),
    .store_data_i(store_data_i), .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_data_o(wb_data_o), .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o), .valid_o(valid_o)
`ifdef MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] data, input logic [4:0] rd, input logic we,
                      input logic chk, input logic mis);
    exp_t e;
    e.data = data; e.rd = rd; e.we = we; e.chk = chk; e.mis = mis;
    sb.push_back(e);
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
    valid_i = 1'b1; alu_result_i = alu; store_data_i = sd; rd_addr_i = rd;
    reg_write_i = rw; mem_read_i = mr; mem_write_i = mw; funct3_i = f3;
  endtask

  task automatic clear_in();
    valid_i = 1'b0; alu_result_i = '0; store_data_i = '0; rd_addr_i = '0; reg_write_i = 1'b0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
  endtask

  // Retirement monitor; any valid_o with nothing queued is a spurious pulse.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {31'd0, valid_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ret_reg_write", {31'd0, reg_write_o}, {31'd0, e.we});
        if (e.chk) begin
          check("ret_wb_data", wb_data_o, e.data);
          check("ret_rd_addr", {27'd0, rd_addr_o}, {27'd0, e.rd});
        end
`ifdef MISALIGN_TRAP_EN
        check("ret_misalign", {31'd0, misalign_o}, {31'd0, e.mis});
`endif
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    clear_in();
    #2;
    check("rst_wb_data", wb_data_o, 32'h0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_reg_write", {31'd0, reg_write_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_addr", dmem_addr_o, 32'h0);
    @(negedge clk_i) rst_i = 1'b0;

    // ALU op, then one with rd=0 whose write must be suppressed.
    @(negedge clk_i) set_op(32'h1234, 0, 5'd5, 1, 0, 0, 3'b010);
    push(32'h1234, 5'd5, 1'b1, 1'b1, 1'b0);
    #1 check("alu_stall", {31'd0, stall_o}, 32'd0);
    check("alu_req", {31'd0, dmem_req_o}, 32'd0);
    @(negedge clk_i) set_op(32'h77, 0, 5'd0, 1, 0, 0, 3'b000);
    push(32'h77, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i) clear_in();

    // LB at 0x103, granted at once, rvalid two cycles later.
    @(negedge clk_i) set_op(32'h103, 0, 5'd7, 1, 1, 0, 3'b000);
    dmem_gnt_i = 1'b1;
    push(32'hFFFF_FF80, 5'd7, 1'b1, 1'b1, 1'b0);
    #1 check("lb_req", {31'd0, dmem_req_o}, 32'd1);
    check("lb_addr", dmem_addr_o, 32'h100);
    check("lb_we", {31'd0, dmem_we_o}, 32'd0);
    check("lb_stall_gnt", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i) clear_in();
    #1 check("lb_wait_stall", {31'd0, stall_o}, 32'd1);
    check("lb_wait_req", {31'd0, dmem_req_o}, 32'd0);
    @(negedge clk_i) dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FF_0000;
    #1 check("lb_wait_stall2", {31'd0, stall_o}, 32'd1);
    @(negedge clk_i) clear_in();

    // Stray rvalid and gnt while idle must be ignored.
    @(negedge clk_i) dmem_rvalid_i = 1'b1; dmem_gnt_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    #1 check("idle_stray_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i) clear_in();

    // SH at 0x202 with grant delayed three cycles.
    @(negedge clk_i) set_op(32'h202, 32'h0000_ABCD, 5'd6, 1, 0, 1, 3'b001);
    for (int i = 0; i < 3; i++) begin
      #1 check("sh_stall", {31'd0, stall_o}, 32'd1);
      check("sh_req", {31'd0, dmem_req_o}, 32'd1);
      check("sh_be", {28'd0, dmem_be_o}, {28'd0, 4'b1100});
      check("sh_wdata", dmem_wdata_o, 32'hABCD_ABCD);
      check("sh_addr", dmem_addr_o, 32'h200);
      @(negedge clk_i);
    end
    dmem_gnt_i = 1'b1;
    push(32'h0, 5'd6, 1'b0, 1'b0, 1'b0);
    #1 check("sh_stall_gnt", {31'd0, stall_o}, 32'd0);
    check("sh_we", {31'd0, dmem_we_o}, 32'd1);

    // SB at 0x001 with read+write both set: handled as a store.
    @(negedge clk_i) set_op(32'h001, 32'h1234_5678, 5'd8, 1, 1, 1, 3'b000);
    dmem_gnt_i = 1'b1;
    push(32'h0, 5'd8, 1'b0, 1'b0, 1'b0);
    #1 check("sb_be", {28'd0, dmem_be_o}, {28'd0, 4'b0010});
    check("sb_wdata", dmem_wdata_o, 32'h7878_7878);
    check("sb_we", {31'd0, dmem_we_o}, 32'd1);

    // SW at 0x10.
    @(negedge clk_i) set_op(32'h010, 32'hCAFE_F00D, 5'd2, 0, 0, 1, 3'b010);
    dmem_gnt_i = 1'b1;
    push(32'h0, 5'd2, 1'b0, 1'b0, 1'b0);
    #1 check("sw_be", {28'd0, dmem_be_o}, {28'd0, 4'b1111});
    check("sw_wdata", dmem_wdata_o, 32'hCAFE_F00D);
    @(negedge clk_i) clear_in();

    // LHU at 0x2 with an ALU op waiting behind it.
    @(negedge clk_i) set_op(32'h002, 0, 5'd9, 1, 1, 0, 3'b101);
    dmem_gnt_i = 1'b1;
    push(32'h0000_8001, 5'd9, 1'b1, 1'b1, 1'b0);
    #1 check("lhu_be", {28'd0, dmem_be_o}, {28'd0, 4'b1100});
    @(negedge clk_i) clear_in(); set_op(32'h55, 0, 5'd3, 1, 0, 0, 3'b000);
    push(32'h55, 5'd3, 1'b1, 1'b1, 1'b0);
    #1 check("lhu_hold_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk_i) dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8001_0000;
    @(negedge clk_i) dmem_rvalid_i = 1'b0;
    #1 check("alu_after_load_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i) clear_in();

    // LH sign-extends the low half; LW passes the word through.
    @(negedge clk_i) set_op(32'h000, 0, 5'd10, 1, 1, 0, 3'b001);
    dmem_gnt_i = 1'b1;
    push(32'hFFFF_9ABC, 5'd10, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i) clear_in(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_9ABC;
    @(negedge clk_i) clear_in(); set_op(32'h020, 0, 5'd11, 1, 1, 0, 3'b010);
    dmem_gnt_i = 1'b1;
    push(32'h8765_4321, 5'd11, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i) clear_in(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8765_4321;
    @(negedge clk_i) clear_in();

    // Reset while a load is outstanding; the late rvalid must not retire anything.
    @(negedge clk_i) set_op(32'h040, 0, 5'd4, 1, 1, 0, 3'b010);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i) clear_in();
    #1 check("pre_rst_stall", {31'd0, stall_o}, 32'd1);
    #1 rst_i = 1'b1;
    #1 check("midrst_wb_data", wb_data_o, 32'h0);
    check("midrst_rd", {27'd0, rd_addr_o}, 32'd0);
    check("midrst_reg_write", {31'd0, reg_write_o}, 32'd0);
    check("midrst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i) rst_i = 1'b0;
    @(negedge clk_i) dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
    @(negedge clk_i) clear_in();
    #1 check("late_rvalid_wb", wb_data_o, 32'h0);
    check("late_rvalid_stall", {31'd0, stall_o}, 32'd0);

`ifdef MISALIGN_TRAP_EN
    // Misaligned LW traps without a request; an aligned op afterwards clears misalign_o.
    @(negedge clk_i) set_op(32'h105, 0, 5'd12, 1, 1, 0, 3'b010);
    push(32'h105, 5'd12, 1'b0, 1'b1, 1'b1);
    #1 check("mis_req", {31'd0, dmem_req_o}, 32'd0);
    check("mis_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i) set_op(32'h66, 0, 5'd13, 1, 0, 0, 3'b001);
    push(32'h66, 5'd13, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i) clear_in();
`endif

    repeat (2) @(negedge clk_i);
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
